// File: rtl/ptp_event_parser.sv
// PTP event parser: walks VLAN tags, matches IPv4/UDP:319 or L2 0x88F7 event
// messages, and queues {is_l2, vlan_n, msgid, seqid, ts} records in a FIFO.
module ptp_event_parser #(
    parameter int unsigned MAX_VLAN   = 2,
    parameter int unsigned TS_W       = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] EVENT_MASK = 16'h0005,
    parameter bit          L2_EN      = 1'b1,
    parameter bit          TS_AT_SOP  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   ptp_data,
    input  logic                          ptp_valid,
    input  logic                          ptp_sop,
    input  logic                          ptp_eop,
    input  logic [1:0]                    ptp_mod,
    input  logic [TS_W-1:0]               ptp_time,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [TS_W+23:0]              rec_data,
    output logic [$clog2(FIFO_DEPTH):0]   rec_level,
    output logic                          ptp_found,
    output logic [15:0]                   drop_cnt
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned REC_W = TS_W + 24;
    localparam logic [1:0]  MAXV  = MAX_VLAN[1:0];
    localparam logic [AW:0] FULL  = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_ETH,
        S_IP,
        S_UDP,
        S_PTP_HDR,
        S_PTP_SEQ,
        S_MATCH,
        S_NOMATCH
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        w_q, w_d;
    logic [1:0]        k_q, k_d;
    logic              l2_q, l2_d;
    logic [3:0]        msg_q, msg_d;
    logic [15:0]       seq_q, seq_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              hit;

    logic [4:0]        kx;
    logic [4:0]        idx_eth;
    logic [4:0]        idx_ip;
    logic [4:0]        idx_udp;
    logic [4:0]        idx_hdr;
    logic [4:0]        idx_seq;
    logic              is_tag;

    logic [AW:0]       wp_q, rp_q;
    logic [REC_W-1:0]  mem_q [FIFO_DEPTH];
    logic              found_q;
    logic [15:0]       drop_q;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push_req;
    logic              push_ok;
    logic              drop;
    logic [TS_W-1:0]   ts_rec;
    logic [REC_W-1:0]  rec_new;

    assign kx      = {3'b000, k_q};
    assign idx_eth = 5'd3 + kx;
    assign idx_ip  = 5'd5 + kx;
    assign idx_udp = 5'd9 + kx;
    assign idx_hdr = 5'd10 + kx;
    assign idx_seq = l2_q ? (5'd11 + kx) : (5'd18 + kx);
    assign is_tag  = (ptp_data[31:16] == 16'h8100) ||
                     (ptp_data[31:16] == 16'h88A8);

    // Parser next state: word position, tag count and captured fields.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        k_d     = k_q;
        l2_d    = l2_q;
        msg_d   = msg_q;
        seq_d   = seq_q;
        ts_d    = ts_q;
        hit     = 1'b0;
        if (ptp_valid) begin
            if (ptp_sop) begin
                state_d = ptp_eop ? S_IDLE : S_ETH;
                w_d     = 5'd1;
                k_d     = 2'd0;
                l2_d    = 1'b0;
                msg_d   = 4'h0;
                seq_d   = 16'h0000;
                ts_d    = ptp_time;
            end else begin
                if (w_q != 5'h1F) begin
                    w_d = w_q + 5'd1;
                end
                unique case (state_q)
                    S_ETH: begin
                        if (w_q == idx_eth) begin
                            if (is_tag) begin
                                if (k_q < MAXV) begin
                                    k_d = k_q + 2'd1;
                                end else begin
                                    state_d = S_NOMATCH;
                                end
                            end else if (ptp_data[31:16] == 16'h0800 &&
                                         ptp_data[15:8] == 8'h45) begin
                                state_d = S_IP;
                            end else if (L2_EN &&
                                         ptp_data[31:16] == 16'h88F7 &&
                                         ptp_data[3:0] == 4'h2 &&
                                         EVENT_MASK[ptp_data[11:8]]) begin
                                l2_d    = 1'b1;
                                msg_d   = ptp_data[11:8];
                                state_d = S_PTP_SEQ;
                            end else begin
                                state_d = S_NOMATCH;
                            end
                        end
                    end
                    S_IP: begin
                        if (w_q == idx_ip) begin
                            state_d = (ptp_data[7:0] == 8'h11) ?
                                      S_UDP : S_NOMATCH;
                        end
                    end
                    S_UDP: begin
                        if (w_q == idx_udp) begin
                            state_d = (ptp_data[31:16] == 16'h013F) ?
                                      S_PTP_HDR : S_NOMATCH;
                        end
                    end
                    S_PTP_HDR: begin
                        if (w_q == idx_hdr) begin
                            msg_d   = ptp_data[11:8];
                            state_d = EVENT_MASK[ptp_data[11:8]] ?
                                      S_PTP_SEQ : S_NOMATCH;
                        end
                    end
                    S_PTP_SEQ: begin
                        if (w_q == idx_seq) begin
                            if (!ptp_eop || ptp_mod <= 2'd2) begin
                                seq_d   = ptp_data[31:16];
                                state_d = S_MATCH;
                                hit     = 1'b1;
                            end else begin
                                state_d = S_NOMATCH;
                            end
                        end
                    end
                    S_MATCH: begin
                        hit = 1'b1;
                    end
                    default: begin
                    end
                endcase
                if (ptp_eop) begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    // Parser state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            k_q     <= '0;
            l2_q    <= 1'b0;
            msg_q   <= '0;
            seq_q   <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            k_q     <= k_d;
            l2_q    <= l2_d;
            msg_q   <= msg_d;
            seq_q   <= seq_d;
            ts_q    <= ts_d;
        end
    end

    assign push_req  = ptp_valid && !ptp_sop && ptp_eop && hit;
    assign ts_rec    = TS_AT_SOP ? ts_q : ptp_time;
    assign rec_new   = {l2_q, k_q, 1'b0, msg_q, seq_d, ts_rec};

    assign rec_level = wp_q - rp_q;
    assign empty     = (rec_level == '0);
    assign full      = (rec_level == FULL);
    assign pop       = !empty && rec_ready;
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    // FIFO pointers, found pulse and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            found_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            if (push_ok) begin
                wp_q <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= rp_q + 1'b1;
            end
            found_q <= push_ok;
            if (drop && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Record storage; contents are only visible through a valid read pointer.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wp_q[AW-1:0]] <= rec_new;
        end
    end

    assign rec_valid = !empty;
    assign rec_data  = empty ? '0 : mem_q[rp_q[AW-1:0]];
    assign ptp_found = found_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_ptp_event_parser.sv
// Bench for ptp_event_parser: two instances (SOP and EOP timestamping)
// driven in parallel, checked against a queue of expected records.
module tb_ptp_event_parser;

    localparam int DEPTH = 4;

    typedef struct {
        bit          l2;
        int          ntag;
        logic [2:0]  qinq;
        logic [3:0]  msg;
        logic [15:0] seq;
        logic [15:0] port;
        logic [7:0]  ihl;
        logic [7:0]  proto;
        logic [3:0]  ver;
        logic [15:0] etype;
        int          len;
        logic [1:0]  mod;
        bit          gap;
        bit          exp_match;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] ptp_data;
    logic        ptp_valid;
    logic        ptp_sop;
    logic        ptp_eop;
    logic [1:0]  ptp_mod;
    logic [31:0] ptp_time;
    logic        rec_ready;

    logic        ua_valid, ub_valid;
    logic [55:0] ua_data, ub_data;
    logic [2:0]  ua_level, ub_level;
    logic        ua_found, ub_found;
    logic [15:0] ua_drop, ub_drop;

    ptp_event_parser #(.TS_AT_SOP(1'b1)) u_a (
        .clk(clk), .rst(rst), .ptp_data(ptp_data),
        .ptp_valid(ptp_valid), .ptp_sop(ptp_sop), .ptp_eop(ptp_eop),
        .ptp_mod(ptp_mod), .ptp_time(ptp_time),
        .rec_valid(ua_valid), .rec_ready(rec_ready), .rec_data(ua_data),
        .rec_level(ua_level), .ptp_found(ua_found), .drop_cnt(ua_drop)
    );

    ptp_event_parser #(.TS_AT_SOP(1'b0)) u_b (
        .clk(clk), .rst(rst), .ptp_data(ptp_data),
        .ptp_valid(ptp_valid), .ptp_sop(ptp_sop), .ptp_eop(ptp_eop),
        .ptp_mod(ptp_mod), .ptp_time(ptp_time),
        .rec_valid(ub_valid), .rec_ready(rec_ready), .rec_data(ub_data),
        .rec_level(ub_level), .ptp_found(ub_found), .drop_cnt(ub_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          ncmp = 0;
    int          nfail = 0;
    int          npop = 0;
    bit          mon_en = 0;
    bit          pend = 0;
    bit          pend_rst = 0;
    bit          rdy_eop = 0;
    logic        exp_found = 1'b0;
    logic [15:0] exp_drop = 16'h0;
    logic [55:0] exp_a, exp_b;
    logic [31:0] ts_sop, ts_eop;
    logic [55:0] qa[$];
    logic [55:0] qb[$];
    logic [31:0] fw [32];
    int          fn;
    vec_t        tv [15];

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input bit l2, input int ntag,
                                input logic [2:0] qinq, input logic [3:0] msg,
                                input logic [15:0] seq, input bit exp);
        vec_t v;
        v.l2 = l2;
        v.ntag = ntag;
        v.qinq = qinq;
        v.msg = msg;
        v.seq = seq;
        v.port = 16'h013F;
        v.ihl = 8'h45;
        v.proto = 8'h11;
        v.ver = 4'h2;
        v.etype = 16'h0000;
        v.len = 0;
        v.mod = 2'd0;
        v.gap = 1'b0;
        v.exp_match = exp;
        return v;
    endfunction

    // Scoreboard/monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid_a", 64'(ua_valid), 64'(qa.size() != 0));
            chk("valid_b", 64'(ub_valid), 64'(qb.size() != 0));
            chk("level_a", 64'(ua_level), 64'(qa.size()));
            chk("level_b", 64'(ub_level), 64'(qb.size()));
            chk("found_a", 64'(ua_found), 64'(exp_found));
            chk("found_b", 64'(ub_found), 64'(exp_found));
            chk("drop_a", 64'(ua_drop), 64'(exp_drop));
            chk("drop_b", 64'(ub_drop), 64'(exp_drop));
            if (ua_valid && rec_ready) begin
                if (qa.size() == 0) begin
                    chk("data_a_unexp", 64'(ua_data), 64'h0);
                end else begin
                    chk("data_a", 64'(ua_data), 64'(qa.pop_front()));
                end
                npop++;
            end
            if (ub_valid && rec_ready) begin
                if (qb.size() == 0) begin
                    chk("data_b_unexp", 64'(ub_data), 64'h0);
                end else begin
                    chk("data_b", 64'(ub_data), 64'(qb.pop_front()));
                end
            end
            exp_found = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (pend_rst) begin
            qa.delete();
            qb.delete();
            exp_drop = 16'h0;
            exp_found = 1'b0;
            pend_rst = 0;
            pend = 0;
        end
        if (pend) begin
            if (qa.size() < DEPTH) begin
                qa.push_back(exp_a);
                qb.push_back(exp_b);
                exp_found = 1'b1;
            end else if (exp_drop != 16'hFFFF) begin
                exp_drop = exp_drop + 16'd1;
            end
            pend = 0;
        end
        @(posedge clk);
        #1;
        ptp_time = ptp_time + 32'd7;
    endtask

    task automatic beat(input logic [31:0] d, input logic v, input logic s,
                        input logic e, input logic [1:0] m);
        ptp_data = d;
        ptp_valid = v;
        ptp_sop = s;
        ptp_eop = e;
        ptp_mod = m;
        if (v && s) ts_sop = ptp_time;
        if (v && e) ts_eop = ptp_time;
    endtask

    task automatic idle();
        beat(32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
    endtask

    task automatic build(input vec_t v);
        int k;
        k = v.ntag;
        for (int i = 0; i < 32; i++) begin
            fw[i] = {8'(i), 8'hC3, 8'h5A, 8'(i + 1)};
        end
        for (int t = 0; t < k; t++) begin
            fw[3 + t] = {(v.qinq[t] ? 16'h88A8 : 16'h8100), 16'h0064};
        end
        if (v.l2) begin
            fw[3 + k] = {(v.etype != 0 ? v.etype : 16'h88F7),
                         4'h0, v.msg, 4'h0, v.ver};
            fw[11 + k] = {v.seq, 16'h0000};
            fn = 14 + k;
        end else begin
            fw[3 + k] = {(v.etype != 0 ? v.etype : 16'h0800), v.ihl, 8'h00};
            fw[5 + k] = {16'h4000, 8'h40, v.proto};
            fw[9 + k] = {v.port, 16'h0040};
            fw[10 + k] = {16'h0000, 4'h0, v.msg, 8'h02};
            fw[18 + k] = {v.seq, 16'h0000};
            fn = 21 + k;
        end
        if (v.len != 0) fn = v.len;
    endtask

    task automatic send(input vec_t v);
        build(v);
        for (int i = 0; i < fn; i++) begin
            if (v.gap && (i % 4) == 2) begin
                beat(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 2'd3);
                tick();
            end
            beat(fw[i], 1'b1, i == 0, i == fn - 1,
                 (i == fn - 1) ? v.mod : 2'd0);
            if (i == fn - 1) begin
                if (rdy_eop) rec_ready = 1'b1;
                if (v.exp_match) begin
                    pend = 1;
                    exp_a = {v.l2, 2'(v.ntag), 1'b0, v.msg, v.seq, ts_sop};
                    exp_b = {v.l2, 2'(v.ntag), 1'b0, v.msg, v.seq, ts_eop};
                end
            end
            tick();
        end
        if (rdy_eop) rec_ready = 1'b0;
        ptp_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (qa.size() != 0 && n < 40) begin
            idle();
            n++;
        end
        chk("drain_timeout", 64'(qa.size()), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        vec_t v;

        tv[0]  = mk(1'b0, 0, 3'b000, 4'h0, 16'h1234, 1'b1);
        tv[1]  = mk(1'b1, 2, 3'b001, 4'h2, 16'hBEEF, 1'b1);
        tv[2]  = mk(1'b1, 3, 3'b001, 4'h2, 16'hBEEF, 1'b0);
        tv[3]  = mk(1'b0, 0, 3'b000, 4'h8, 16'h0003, 1'b0);
        tv[4]  = mk(1'b0, 0, 3'b000, 4'h0, 16'h0004, 1'b0);
        tv[4].port = 16'h0140;
        tv[5]  = mk(1'b0, 0, 3'b000, 4'h0, 16'h0005, 1'b0);
        tv[5].ihl = 8'h46;
        tv[6]  = mk(1'b0, 0, 3'b000, 4'h0, 16'h0006, 1'b0);
        tv[6].len = 18;
        tv[7]  = mk(1'b0, 1, 3'b000, 4'h2, 16'h0707, 1'b1);
        tv[7].gap = 1'b1;
        tv[8]  = mk(1'b1, 0, 3'b000, 4'h1, 16'h0808, 1'b0);
        tv[9]  = mk(1'b0, 0, 3'b000, 4'h0, 16'h0909, 1'b1);
        tv[9].len = 19;
        tv[9].mod = 2'd2;
        tv[10] = mk(1'b0, 0, 3'b000, 4'h0, 16'h0A0A, 1'b0);
        tv[10].len = 19;
        tv[10].mod = 2'd3;
        tv[11] = mk(1'b0, 0, 3'b000, 4'h0, 16'h0B0B, 1'b0);
        tv[11].proto = 8'h06;
        tv[12] = mk(1'b1, 0, 3'b000, 4'h0, 16'h0C0C, 1'b0);
        tv[12].ver = 4'h1;
        tv[13] = mk(1'b0, 0, 3'b000, 4'h0, 16'h0D0D, 1'b0);
        tv[13].etype = 16'h86DD;
        tv[14] = mk(1'b1, 1, 3'b001, 4'h0, 16'h0E0E, 1'b1);

        rst = 1'b1;
        ptp_data = 32'h0;
        ptp_valid = 1'b0;
        ptp_sop = 1'b0;
        ptp_eop = 1'b0;
        ptp_mod = 2'd0;
        ptp_time = 32'h0000_00F9;
        rec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ua_valid), 64'h0);
        chk("rst_data", 64'(ua_data), 64'h0);
        chk("rst_level", 64'(ua_level), 64'h0);
        chk("rst_found", 64'(ua_found), 64'h0);
        chk("rst_drop", 64'(ua_drop), 64'h0);
        rst = 1'b0;
        mon_en = 1;
        rec_ready = 1'b1;

        for (int i = 0; i < 15; i++) begin
            p0 = npop;
            send(tv[i]);
            idle();
            chk($sformatf("vec%0d_records", i), 64'(npop - p0),
                64'(tv[i].exp_match));
        end
        drain();

        p0 = npop;
        v = mk(1'b0, 0, 3'b000, 4'h0, 16'h1111, 1'b1);
        build(v);
        for (int i = 0; i < 8; i++) begin
            beat(fw[i], 1'b1, i == 0, 1'b0, 2'd0);
            tick();
        end
        send(mk(1'b0, 0, 3'b000, 4'h0, 16'h2222, 1'b1));
        drain();
        chk("abort_records", 64'(npop - p0), 64'h1);

        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(mk(1'b0, 0, 3'b000, 4'h0, 16'(16'h3000 + i), 1'b1));
        end
        idle();
        idle();
        chk("full_level", 64'(ua_level), 64'h4);
        chk("full_drop", 64'(ua_drop), 64'h1);
        rdy_eop = 1;
        send(mk(1'b1, 0, 3'b000, 4'h0, 16'h3006, 1'b1));
        rdy_eop = 0;
        idle();
        chk("pushpop_level", 64'(ua_level), 64'h4);
        chk("pushpop_drop", 64'(ua_drop), 64'h1);

        v = mk(1'b0, 0, 3'b000, 4'h0, 16'h5555, 1'b1);
        build(v);
        for (int i = 0; i < 12; i++) begin
            beat(fw[i], 1'b1, i == 0, 1'b0, 2'd0);
            tick();
        end
        beat(fw[12], 1'b1, 1'b0, 1'b0, 2'd0);
        rst = 1'b1;
        pend_rst = 1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 64'(ua_valid), 64'h0);
        chk("mrst_data", 64'(ua_data), 64'h0);
        chk("mrst_level", 64'(ua_level), 64'h0);
        chk("mrst_found", 64'(ua_found), 64'h0);
        chk("mrst_drop", 64'(ua_drop), 64'h0);
        chk("mrst_data_b", 64'(ub_data), 64'h0);
        for (int i = 13; i < fn; i++) begin
            beat(fw[i], 1'b1, 1'b0, i == fn - 1, 2'd0);
            tick();
        end
        ptp_valid = 1'b0;
        rec_ready = 1'b1;
        p0 = npop;
        send(mk(1'b0, 0, 3'b000, 4'h0, 16'h6666, 1'b1));
        drain();
        chk("post_rst_records", 64'(npop - p0), 64'h1);

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 ncmp, nfail);
        $finish;
    end

endmodule
